// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared constants, state encoding and helpers for mult_seq
// Purpose: word/product widths, iteration bound, FSM state type and the
//          two's-complement magnitude helper used when preparing operands.
// Ports:   none (package).
package mult_seq_pkg;

    localparam int WORD_W    = 32;
    localparam int PROD_W    = 64;
    localparam int ITER_LAST = 31;
    localparam int CNT_W     = $clog2(ITER_LAST + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // 0x80000000 maps onto itself, which reads correctly as unsigned 2^31.
    function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v,
                                                    input logic is_signed);
        logic [WORD_W-1:0] neg_v;
        neg_v = (~v) + {{(WORD_W-1){1'b0}}, 1'b1};
        return (is_signed && v[WORD_W-1]) ? neg_v : v;
    endfunction

endpackage

// File: rtl/mult_seq_dp.sv
// rtl/mult_seq_dp.sv - shift-add datapath for the sequential multiplier
// Purpose: operand latches, magnitude/sign preparation, radix-2 accumulate,
//          final negate and overflow detect, result register.
// Ports:   clk, rst_n          clock, async active-low reset
//          i_load              capture operands and signedness
//          i_op_unsigned/i_opa/i_opb  raw operands
//          i_prep              convert to magnitudes, clear accumulator
//          i_step              one shift-add iteration
//          i_commit            register final product and overflow
//          o_mplier_zero       remaining multiplier is zero
//          o_prod/o_ovf        held result
module mult_seq_dp
    import mult_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_op_unsigned,
    input  logic [WORD_W-1:0] i_opa,
    input  logic [WORD_W-1:0] i_opb,
    input  logic              i_prep,
    input  logic              i_step,
    input  logic              i_commit,
    output logic              o_mplier_zero,
    output logic [WORD_W-1:0] o_prod,
    output logic              o_ovf
);

    logic              r_unsigned;
    logic              r_neg;
    logic [PROD_W-1:0] r_mcand;
    logic [WORD_W-1:0] r_mplier;
    logic [PROD_W-1:0] r_acc;
    logic [WORD_W-1:0] r_prod;
    logic              r_ovf;

    logic [PROD_W-1:0] w_sum;
    logic [PROD_W-1:0] w_result;
    logic              w_ovf;

    assign w_sum    = r_acc + r_mcand;
    assign w_result = r_neg ? ((~r_acc) + {{(PROD_W-1){1'b0}}, 1'b1}) : r_acc;

    // Signed fit needs bits 63..31 to be a pure sign extension.
    always_comb begin
        w_ovf = 1'b0;
        if (r_unsigned) begin
            w_ovf = |w_result[PROD_W-1:WORD_W];
        end else begin
            w_ovf = !((&w_result[PROD_W-1:WORD_W-1]) || !(|w_result[PROD_W-1:WORD_W-1]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_unsigned <= 1'b0;
            r_neg      <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
        end else if (i_load) begin
            r_unsigned <= i_op_unsigned;
            r_mcand    <= {{(PROD_W-WORD_W){1'b0}}, i_opa};
            r_mplier   <= i_opb;
        end else if (i_prep) begin
            r_mcand  <= {{(PROD_W-WORD_W){1'b0}}, magnitude(r_mcand[WORD_W-1:0], !r_unsigned)};
            r_mplier <= magnitude(r_mplier, !r_unsigned);
            r_neg    <= !r_unsigned && (r_mcand[WORD_W-1] ^ r_mplier[WORD_W-1]);
            r_acc    <= '0;
        end else if (i_step) begin
            if (r_mplier[0]) begin
                r_acc <= w_sum;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_ovf  <= 1'b0;
        end else if (i_commit) begin
            r_prod <= w_result[WORD_W-1:0];
            r_ovf  <= w_ovf;
        end
    end

    assign o_mplier_zero = (r_mplier == '0);
    assign o_prod        = r_prod;
    assign o_ovf         = r_ovf;

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - multi-cycle MULT/MULTU sequencer with start/busy/done handshake
// Purpose: FSM (IDLE, PREP, RUN, FIX, DONE) and iteration counter driving
//          mult_seq_dp. Optional macro MULT_EARLY_OUT_EN leaves RUN as soon
//          as the remaining multiplier is zero.
// Ports:   clk, rst_n          clock, async active-low reset
//          start, op_unsigned, opa, opb  request and operands (bit 0 = MSB)
//          flush               synchronous abort to IDLE
//          busy, done          handshake (done is a one-cycle pulse)
//          prod, ovf           low product word and overflow, held
module mult_seq
    import mult_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_unsigned,
    input  logic [0:WORD_W-1] opa,
    input  logic [0:WORD_W-1] opb,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [0:WORD_W-1] prod,
    output logic              ovf
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;

    logic              w_load;
    logic              w_prep;
    logic              w_step;
    logic              w_commit;
    logic              w_mplier_zero;
    logic              w_last_iter;
    logic [WORD_W-1:0] w_opa;
    logic [WORD_W-1:0] w_opb;
    logic [WORD_W-1:0] w_prod;

    // Descending-range views; numeric value is unchanged (bit 0 stays the MSB).
    assign w_opa = opa;
    assign w_opb = opb;
    assign prod  = w_prod;

    assign w_last_iter = (r_count == CNT_W'(ITER_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_state_nxt = ST_PREP;
                ST_PREP: w_state_nxt = ST_RUN;
                ST_RUN: begin
`ifdef MULT_EARLY_OUT_EN
                    if (w_mplier_zero || w_last_iter) w_state_nxt = ST_FIX;
`else
                    if (w_last_iter) w_state_nxt = ST_FIX;
`endif
                end
                ST_FIX:  w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = start ? ST_PREP : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Every datapath strobe is masked by flush so an abort leaves prod/ovf intact.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        w_load   = 1'b0;
        w_prep   = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            ST_IDLE: w_load = start && !flush;
            ST_PREP: begin
                busy   = 1'b1;
                w_prep = !flush;
            end
            ST_RUN: begin
                busy = 1'b1;
`ifdef MULT_EARLY_OUT_EN
                w_step = !flush && !w_mplier_zero;
`else
                w_step = !flush;
`endif
            end
            ST_FIX: begin
                busy     = 1'b1;
                w_commit = !flush;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_load = start && !flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_prep) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= r_count + 1'b1;
        end
    end

    mult_seq_dp u_dp (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_op_unsigned (op_unsigned),
        .i_opa         (w_opa),
        .i_opb         (w_opb),
        .i_prep        (w_prep),
        .i_step        (w_step),
        .i_commit      (w_commit),
        .o_mplier_zero (w_mplier_zero),
        .o_prod        (w_prod),
        .o_ovf         (ovf)
    );

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        op_unsigned = 1'b0;
    logic [0:31] opa = '0;
    logic [0:31] opb = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [0:31] prod;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_p = '0;
    logic        last_o = 1'b0;

    always #5 clk = ~clk;

    mult_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op_unsigned (op_unsigned),
        .opa         (opa),
        .opb         (opb),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .prod        (prod),
        .ovf         (ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic product, then range test on the result.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit u,
                         output logic [31:0] p, output logic o);
        if (u) begin
            longint unsigned ua, ub, full;
            ua = {32'b0, a};
            ub = {32'b0, b};
            full = ua * ub;
            p = full[31:0];
            o = (full >> 32) != 0;
        end else begin
            longint sa, sb, full;
            logic [31:0] lo;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            full = sa * sb;
            lo = full[31:0];
            p = lo;
            o = full != longint'($signed(lo));
        end
    endtask

    function automatic int exp_lat(input logic [31:0] b, input bit u);
`ifdef MULT_EARLY_OUT_EN
        logic [31:0] m;
        m = (!u && b[31]) ? (~b + 32'd1) : b;
        if (m == 0) return 3;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) return (i + 4 > 34) ? 34 : i + 4;
        end
        return 3;
`else
        return 34;
`endif
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit u);
        opa = a;
        opb = b;
        op_unsigned = u;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input bit u, input int cyc0);
        int cyc;
        int busy_low;
        logic [31:0] ep;
        logic eo;
        cyc = cyc0;
        busy_low = 0;
        while (!done && cyc < 100) begin
            if (!busy) busy_low++;
            @(posedge clk);
            #1;
            cyc++;
        end
        model(a, b, u, ep, eo);
        check({tag, "_lat"}, cyc, exp_lat(b, u));
        check({tag, "_busylow"}, busy_low, 0);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_prod"}, prod, ep);
        check({tag, "_ovf"}, ovf, eo);
        last_p = ep;
        last_o = eo;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input bit u);
        issue(a, b, u);
        wait_done(tag, a, b, u, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic count_dones(input string tag, input int n);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) k++;
        end
        check(tag, k, 0);
    endtask

    initial begin
        logic [31:0] a, b;
        bit u;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_prod", prod, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("u_basic", 32'h0000FFFF, 32'h00010001, 1'b1);
        run("s_neg3x7", 32'hFFFFFFFD, 32'h00000007, 1'b0);
        run("s_min_x_m1", 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run("u_ovf", 32'h00010000, 32'h00010000, 1'b1);
        run("s_ovf", 32'h00010000, 32'h00010000, 1'b0);
        run("u_zero", 32'h12345678, 32'h00000000, 1'b1);
        run("u_9x5", 32'd9, 32'd5, 1'b1);
        run("s_mmax", 32'h80000000, 32'h80000000, 1'b0);
        run("u_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

        // start pulsed while RUN: must be ignored
        a = $urandom;
        b = 32'h80000000 | $urandom;
        issue(a, b, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        opa = ~a;
        opb = 32'h3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign_start", a, b, 1'b1, 7);
        count_dones("ign_single_done", 40);

        // back-to-back: new start in the DONE cycle
        a = $urandom;
        b = 32'hC0000000 | $urandom;
        issue(a, b, 1'b0);
        wait_done("b2b_first", a, b, 1'b0, 0);
        a = $urandom;
        b = 32'h40000000 | $urandom;
        issue(a, b, 1'b1);
        check("b2b_busy_after", busy, 1);
        wait_done("b2b_second", a, b, 1'b1, 0);
        @(posedge clk);
        #1;

        // flush at RUN cycle 10
        issue($urandom, 32'hF0000000 | $urandom, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        check("flush_prod_kept", prod, last_p);
        check("flush_ovf_kept", ovf, last_o);
        count_dones("flush_no_done", 45);

        // flush beats start
        opa = 32'd3;
        opb = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_prio_busy", busy, 0);

        // asynchronous reset mid-RUN
        issue(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_prod", prod, 0);
        check("arst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("after_rst", 32'hFFFFFFFF, 32'h00000002, 1'b0);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
            u = bit'($urandom_range(0, 1));
            run($sformatf("rnd%0d", i), a, b, u);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
